// File: rtl/rd_arb_pkg.sv
// Shared types and constants for the AXI read-command arbiter.
// - arb_state_t / IDLE, ISSUE, BURST : arbiter FSM encoding
// - AXI_BURST_* : AXI read burst-type encodings
// - rr_next() : circular successor of a requester index
package rd_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t ISSUE = 2'd1;
  localparam arb_state_t BURST = 2'd2;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  // Circular successor of idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   pending_i  : requesters with a burst waiting
//   ptr_i      : highest-priority index this round
//   gnt_o      : one-hot grant (first pending at or after ptr_i, circular)
//   gnt_idx_o  : binary index of the grant
//   gnt_vld_o  : any pending requester found
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         pending_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       gnt_vld_o
);
  localparam int unsigned PtrW = $clog2(NUM_REQ);

  always_comb begin
    logic [PtrW-1:0] idx;
    idx       = '0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PtrW'((32'(ptr_i) + k) % NUM_REQ);
      if (!gnt_vld_o && pending_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        gnt_vld_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI burst-read command port among NUM_REQ readers.
// Each requester owns a one-deep pending slot; slots are granted round-robin, a one-cycle
// start_read_o is issued with the slot's fields, R-channel valid/last are routed to the owner
// and ownership is released on the accepted last beat.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   req_start_read_i / req_read_*_i : per-requester command pulse and packed fields
//   req_busy_o, req_rvalid_o, req_rlast_o, req_done_o, req_overflow_o : per-requester status
//   start_read_o, read_*_o      : command to the burst master
//   rvalid_i, rready_i, rlast_i : monitored R channel
//   wdog_err_o                  : sticky watchdog error
// Optional: define RD_ARB_WDOG_EN to add a BURST watchdog (WDOG_CYCLES) that force-releases the
// owner when no beat arrives in time; otherwise wdog_err_o is tied 0.
module axi_read_arbiter
  import rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 32
`ifdef RD_ARB_WDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES = 1024
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_start_read_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_read_addr_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_read_len_i,
  input  logic [NUM_REQ*3-1:0]          req_read_size_i,
  input  logic [NUM_REQ*2-1:0]          req_read_burst_i,
  output logic [NUM_REQ-1:0]            req_busy_o,
  output logic [NUM_REQ-1:0]            req_rvalid_o,
  output logic [NUM_REQ-1:0]            req_rlast_o,
  output logic [NUM_REQ-1:0]            req_done_o,
  output logic                          start_read_o,
  output logic [ADDR_WIDTH-1:0]         read_addr_o,
  output logic [LEN_WIDTH-1:0]          read_len_o,
  output logic [2:0]                    read_size_o,
  output logic [1:0]                    read_burst_o,
  input  logic                          rvalid_i,
  input  logic                          rready_i,
  input  logic                          rlast_i,
  output logic [NUM_REQ-1:0]            req_overflow_o,
  output logic                          wdog_err_o
);
  localparam int unsigned PtrW = $clog2(NUM_REQ);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } cmd_t;

  arb_state_t         state_q, state_d;
  logic [PtrW-1:0]    owner_q, owner_d;
  logic [PtrW-1:0]    rr_q, rr_d;
  logic [NUM_REQ-1:0] valid_q, valid_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] ovf_q, ovf_d;
  logic [NUM_REQ-1:0] accept;
  cmd_t               cmd_q [NUM_REQ];

  logic [NUM_REQ-1:0] gnt;
  logic [PtrW-1:0]    gnt_idx;
  logic               gnt_vld;
  logic               beat;
  logic               wdog_fire;
  logic               release_w;

  // In IDLE nothing is in flight, so every valid slot is a pending request.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .pending_i (valid_q),
    .ptr_i     (rr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign beat      = rvalid_i & rready_i;
  assign release_w = (state_q == BURST) && ((beat && rlast_i) || wdog_fire);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    valid_d = valid_q;
    done_d  = '0;
    ovf_d   = ovf_q;
    accept  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // The owner's slot frees on the release edge, so a re-request then is accepted.
      if (req_start_read_i[i]) begin
        if (!valid_q[i] || (release_w && owner_q == PtrW'(i))) accept[i] = 1'b1;
        else                                                    ovf_d[i]  = 1'b1;
      end
      if (release_w && owner_q == PtrW'(i)) begin
        done_d[i]  = 1'b1;
        valid_d[i] = 1'b0;
      end
      if (accept[i]) valid_d[i] = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          owner_d = gnt_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = BURST;
      BURST: begin
        if (release_w) begin
          rr_d    = PtrW'(rr_next(32'(owner_q), NUM_REQ));
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      valid_q <= '0;
      done_q  <= '0;
      ovf_q   <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) cmd_q[i] <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          cmd_q[i].addr  <= req_read_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
          cmd_q[i].len   <= req_read_len_i[i*LEN_WIDTH +: LEN_WIDTH];
          cmd_q[i].size  <= req_read_size_i[i*3 +: 3];
          cmd_q[i].burst <= req_read_burst_i[i*2 +: 2];
        end
      end
    end
  end

  always_comb begin
    start_read_o = 1'b0;
    read_addr_o  = '0;
    read_len_o   = '0;
    read_size_o  = '0;
    read_burst_o = '0;
    if (state_q == ISSUE) begin
      start_read_o = 1'b1;
      read_addr_o  = cmd_q[owner_q].addr;
      read_len_o   = cmd_q[owner_q].len;
      read_size_o  = cmd_q[owner_q].size;
      read_burst_o = cmd_q[owner_q].burst;
    end
  end

  always_comb begin
    req_rvalid_o = '0;
    req_rlast_o  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (state_q == BURST && owner_q == PtrW'(i)) begin
        req_rvalid_o[i] = rvalid_i;
        req_rlast_o[i]  = rlast_i;
      end
    end
  end

  assign req_busy_o     = valid_q;
  assign req_done_o     = done_q;
  assign req_overflow_o = ovf_q;

`ifdef RD_ARB_WDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);

  logic [WdogW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic             wdog_err_q;

  // Fires in the WDOG_CYCLES-th consecutive beat-less BURST cycle.
  assign wdog_fire = (state_q == BURST) && !beat && (wdog_cnt_q == WdogW'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_cnt_d = wdog_cnt_q + 1'b1;
    if (state_q != BURST || beat || wdog_fire) wdog_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      if (wdog_fire) wdog_err_q <= 1'b1;
    end
  end

  assign wdog_err_o = wdog_err_q;
`else
  assign wdog_fire  = 1'b0;
  assign wdog_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_read_arbiter.sv
module tb_axi_read_arbiter;
  import rd_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_start_read = '0;
  logic [63:0] req_read_addr = '0;
  logic [63:0] req_read_len = '0;
  logic [5:0]  req_read_size = '0;
  logic [3:0]  req_read_burst = '0;
  logic [1:0]  req_busy, req_rvalid, req_rlast, req_done, req_overflow;
  logic        start_read;
  logic [31:0] read_addr, read_len;
  logic [2:0]  read_size;
  logic [1:0]  read_burst;
  logic        rvalid = 1'b0, rready = 1'b0, rlast = 1'b0;
  logic        wdog_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_read_arbiter #(
    .NUM_REQ    (2),
    .ADDR_WIDTH (32),
    .LEN_WIDTH  (32)
`ifdef RD_ARB_WDOG_EN
    ,
    .WDOG_CYCLES (16)
`endif
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_start_read_i (req_start_read),
    .req_read_addr_i  (req_read_addr),
    .req_read_len_i   (req_read_len),
    .req_read_size_i  (req_read_size),
    .req_read_burst_i (req_read_burst),
    .req_busy_o       (req_busy),
    .req_rvalid_o     (req_rvalid),
    .req_rlast_o      (req_rlast),
    .req_done_o       (req_done),
    .start_read_o     (start_read),
    .read_addr_o      (read_addr),
    .read_len_o       (read_len),
    .read_size_o      (read_size),
    .read_burst_o     (read_burst),
    .rvalid_i         (rvalid),
    .rready_i         (rready),
    .rlast_i          (rlast),
    .req_overflow_o   (req_overflow),
    .wdog_err_o       (wdog_err)
  );

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic set_cmd(input int i, input logic [31:0] addr, input logic [31:0] len);
    req_read_addr[i*32 +: 32] = addr;
    req_read_len[i*32 +: 32]  = len;
    req_read_size[i*3 +: 3]   = 3'd3;
    req_read_burst[i*2 +: 2]  = AXI_BURST_INCR;
  endtask

  task automatic pulse(input logic [1:0] m);
    req_start_read = m;
    @(posedge clk); #1;
    req_start_read = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_start_read = '0;
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Polls start_read for a bounded number of cycles; cyc = cycles advanced.
  task automatic wait_start(output bit seen, output int cyc);
    seen = 1'b0;
    cyc  = 0;
    for (int k = 0; k < 20; k++) begin
      if (start_read === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Drives n beats; counts cycles where routing matched owner (owner<0: nobody).
  task automatic send_beats(input int n, input int owner, input bit with_last, input bit adv,
                            output int good, output int bad);
    logic [1:0] exp_v, exp_l;
    good  = 0;
    bad   = 0;
    exp_v = (owner < 0) ? 2'b00 : 2'(1 << owner);
    if (adv) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < n; k++) begin
      rvalid = 1'b1;
      rready = 1'b1;
      rlast  = with_last && (k == n - 1);
      #1;
      exp_l = rlast ? exp_v : 2'b00;
      if (req_rvalid === exp_v && req_rlast === exp_l) good++;
      else bad++;
      @(posedge clk); #1;
    end
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({req_busy, req_rvalid, req_rlast, req_done, req_overflow, start_read, wdog_err} !== '0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0",
               {req_busy, req_rvalid, req_rlast, req_done, req_overflow, start_read, wdog_err});
    end
    checks++;
    if ({read_addr, read_len, read_size, read_burst} !== '0) begin
      errors++;
      $display("FAIL reset_cmd: got %h required 0", {read_addr, read_len, read_size, read_burst});
    end
    apply_reset();
    checks++;
    if ({start_read, req_busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got %b required 000", {start_read, req_busy});
    end
  endtask

  task automatic test_single();
    bit seen; int cyc, good, bad;
    set_cmd(0, 32'h40, 32'd7);
    pulse(2'b01);
    checks++;
    if ({start_read, req_busy} !== 3'b001) begin
      errors++;
      $display("FAIL single_lat1: got start/busy %b required 001", {start_read, req_busy});
    end
    @(posedge clk); #1;
    checks++;
    if ({start_read, read_addr, read_len, read_size, read_burst} !== {1'b1, 32'h40, 32'd7, 3'd3, 2'b01}) begin
      errors++;
      $display("FAIL single_issue: got start=%b addr=%h len=%0d size=%0d burst=%b required 1 40 7 3 01",
               start_read, read_addr, read_len, read_size, read_burst);
    end
    send_beats(8, 0, 1'b1, 1'b1, good, bad);
    checks++;
    if (good !== 8) begin
      errors++;
      $display("FAIL single_route: got %0d good beats required 8", good);
    end
    checks++;
    if ({req_done, req_busy} !== 4'b0100) begin
      errors++;
      $display("FAIL single_done: got done/busy %b required 0100", {req_done, req_busy});
    end
    @(posedge clk); #1;
    checks++;
    if (req_done !== 2'b00) begin
      errors++;
      $display("FAIL single_done_pulse: got %b required 00", req_done);
    end
    wait_start(seen, cyc);
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL single_no_reissue: got start seen=%b required 0", seen);
    end
  endtask

  task automatic test_simultaneous();
    bit seen; int cyc, good, bad;
    apply_reset();
    set_cmd(0, 32'h0, 32'd3);
    set_cmd(1, 32'h100, 32'd3);
    pulse(2'b11);
    wait_start(seen, cyc);
    checks++;
    if (!seen || read_addr !== 32'h0) begin
      errors++;
      $display("FAIL simul_first: got seen=%b addr=%h required 1 00000000", seen, read_addr);
    end
    send_beats(4, 0, 1'b1, 1'b1, good, bad);
    checks++;
    if (good !== 4 || req_busy !== 2'b10) begin
      errors++;
      $display("FAIL simul_burst0: got good=%0d busy=%b required 4 10", good, req_busy);
    end
    // Release cycle is followed by one IDLE cycle before the next ISSUE.
    wait_start(seen, cyc);
    checks++;
    if (!seen || cyc !== 1 || read_addr !== 32'h100) begin
      errors++;
      $display("FAIL simul_second: got seen=%b gap=%0d addr=%h required 1 1 00000100", seen, cyc, read_addr);
    end
    send_beats(4, 1, 1'b1, 1'b1, good, bad);
    checks++;
    if (good !== 4 || req_done !== 2'b10) begin
      errors++;
      $display("FAIL simul_burst1: got good=%0d done=%b required 4 10", good, req_done);
    end
    // Pointer must be back at 0: a new simultaneous pair grants req0 first.
    pulse(2'b11);
    wait_start(seen, cyc);
    checks++;
    if (!seen || read_addr !== 32'h0) begin
      errors++;
      $display("FAIL simul_rr_ptr: got seen=%b addr=%h required 1 00000000", seen, read_addr);
    end
    send_beats(4, 0, 1'b1, 1'b1, good, bad);
    wait_start(seen, cyc);
    send_beats(4, 1, 1'b1, 1'b1, good, bad);
    checks++;
    if (good !== 4 || req_busy !== 2'b00) begin
      errors++;
      $display("FAIL simul_drain: got good=%0d busy=%b required 4 00", good, req_busy);
    end
  endtask

  task automatic test_overflow();
    bit seen; int cyc, good, bad;
    set_cmd(1, 32'h100, 32'd1);
    pulse(2'b10);
    wait_start(seen, cyc);
    checks++;
    if (!seen || read_addr !== 32'h100) begin
      errors++;
      $display("FAIL ovf_issue: got seen=%b addr=%h required 1 00000100", seen, read_addr);
    end
    set_cmd(1, 32'h200, 32'd1);
    pulse(2'b10);
    checks++;
    if (req_overflow !== 2'b10) begin
      errors++;
      $display("FAIL ovf_flag: got %b required 10", req_overflow);
    end
    send_beats(2, 1, 1'b1, 1'b0, good, bad);
    checks++;
    if (good !== 2) begin
      errors++;
      $display("FAIL ovf_burst: got %0d good beats required 2", good);
    end
    wait_start(seen, cyc);
    checks++;
    if (seen !== 1'b0 || req_busy !== 2'b00 || req_overflow !== 2'b10) begin
      errors++;
      $display("FAIL ovf_single_burst: got seen=%b busy=%b ovf=%b required 0 00 10", seen, req_busy, req_overflow);
    end
  endtask

  task automatic test_fairness();
    bit seen; int cyc, good, bad;
    set_cmd(0, 32'h40, 32'd3);
    pulse(2'b01);
    wait_start(seen, cyc);
    set_cmd(1, 32'h180, 32'd0);
    pulse(2'b10);
    send_beats(3, 0, 1'b0, 1'b0, good, bad);
    // Owner re-requests in its own rlast cycle.
    set_cmd(0, 32'h300, 32'd0);
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1; req_start_read = 2'b01;
    @(posedge clk); #1;
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0; req_start_read = 2'b00;
    checks++;
    if ({req_overflow, req_busy, req_done} !== 6'b10_11_01) begin
      errors++;
      $display("FAIL fair_rerequest: got ovf/busy/done %b required 101101", {req_overflow, req_busy, req_done});
    end
    wait_start(seen, cyc);
    checks++;
    if (!seen || read_addr !== 32'h180) begin
      errors++;
      $display("FAIL fair_req1_next: got seen=%b addr=%h required 1 00000180", seen, read_addr);
    end
    send_beats(1, 1, 1'b1, 1'b1, good, bad);
    wait_start(seen, cyc);
    checks++;
    if (!seen || read_addr !== 32'h300) begin
      errors++;
      $display("FAIL fair_req0_after: got seen=%b addr=%h required 1 00000300", seen, read_addr);
    end
    send_beats(1, 0, 1'b1, 1'b1, good, bad);
    checks++;
    if (good !== 1 || req_busy !== 2'b00) begin
      errors++;
      $display("FAIL fair_drain: got good=%0d busy=%b required 1 00", good, req_busy);
    end
  endtask

  task automatic test_rvalid_idle();
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    #1;
    checks++;
    if ({req_rvalid, req_rlast} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_rvalid: got %b required 0000", {req_rvalid, req_rlast});
    end
    @(posedge clk); #1;
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    checks++;
    if ({req_done, start_read} !== 3'b000) begin
      errors++;
      $display("FAIL idle_no_done: got done/start %b required 000", {req_done, start_read});
    end
  endtask

  task automatic test_reset_mid();
    bit seen; int cyc, good, bad;
    apply_reset();
    set_cmd(0, 32'h40, 32'd7);
    pulse(2'b01);
    wait_start(seen, cyc);
    send_beats(3, 0, 1'b0, 1'b1, good, bad);
    rvalid = 1'b1; rready = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_busy, req_rvalid, req_rlast, req_done, req_overflow, start_read} !== '0 || read_addr !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_clear: got %b addr=%h required 0 0",
               {req_busy, req_rvalid, req_rlast, req_done, req_overflow, start_read}, read_addr);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_beats(5, -1, 1'b1, 1'b0, good, bad);
    checks++;
    if (good !== 5) begin
      errors++;
      $display("FAIL rstmid_no_route: got %0d silent beats required 5", good);
    end
    wait_start(seen, cyc);
    checks++;
    if (seen !== 1'b0 || {req_busy, req_done} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_quiet: got seen=%b busy/done=%b required 0 0000", seen, {req_busy, req_done});
    end
  endtask

  task automatic test_wdog();
    bit seen; int cyc, good, bad;
    int k_err;
`ifdef RD_ARB_WDOG_EN
    apply_reset();
    set_cmd(0, 32'h40, 32'd7);
    set_cmd(1, 32'h100, 32'd0);
    pulse(2'b11);
    wait_start(seen, cyc);
    k_err = 0;
    // k=1 is the first BURST cycle; the flag registers after the 16th one.
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (wdog_err === 1'b1) begin
        k_err = k;
        break;
      end
    end
    checks++;
    if (k_err !== 17 || req_done !== 2'b01) begin
      errors++;
      $display("FAIL wdog_fire: got k=%0d done=%b required 17 01", k_err, req_done);
    end
    wait_start(seen, cyc);
    checks++;
    if (!seen || read_addr !== 32'h100) begin
      errors++;
      $display("FAIL wdog_next: got seen=%b addr=%h required 1 00000100", seen, read_addr);
    end
    send_beats(1, 1, 1'b1, 1'b1, good, bad);
    checks++;
    if (good !== 1 || wdog_err !== 1'b1) begin
      errors++;
      $display("FAIL wdog_sticky: got good=%0d err=%b required 1 1", good, wdog_err);
    end
`else
    seen = 1'b0; cyc = 0; good = 0; bad = 0; k_err = 0;
    checks++;
    if (wdog_err !== 1'b0) begin
      errors++;
      $display("FAIL wdog_tied: got %b required 0", wdog_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_overflow();
    test_fairness();
    test_rvalid_idle();
    test_reset_mid();
    test_wdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
